// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
package addsub_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int N_REQ         = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;
endpackage

// File: rtl/adder_sub.sv
// Ripple-carry adder/subtractor: subtraction is a + ~b + 1 with sub as carry-in.
module adder_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_carry;

  assign w_b_eff    = i_b ^ {WIDTH{i_sub}};
  assign w_carry[0] = i_sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign o_sum[i]       = i_a[i] ^ w_b_eff[i] ^ w_carry[i];
    assign w_carry[i + 1] = (i_a[i] & w_b_eff[i]) | (w_carry[i] & (i_a[i] ^ w_b_eff[i]));
  end

  assign o_cout = w_carry[WIDTH];
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign o_ovf  = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one adder_sub between two requesters,
// with a registered valid/ready response channel.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_cout,
  output logic             rsp_ovf
);
  state_t           r_state;
  logic             r_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_id;

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_out;
  logic             r_rsp_cout;
  logic             r_rsp_ovf;

  logic             w_accept;
  logic             w_grant_id;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_grant_id = 1'b0;
    if (&req_valid)
      w_grant_id = r_ptr;
    else if (req_valid[1])
      w_grant_id = 1'b1;
  end

  assign w_accept  = (r_state == ST_IDLE) && (|req_valid);
  assign req_ready = !w_accept ? 2'b00 : (w_grant_id ? 2'b10 : 2'b01);

  adder_sub #(.WIDTH(WIDTH)) u_adder_sub (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_sub  (r_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: operand registers are reset too, so the datapath never sees X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant_id ? req1_a   : req0_a;
            r_b     <= w_grant_id ? req1_b   : req0_b;
            r_sub   <= w_grant_id ? req1_sub : req0_sub;
            r_id    <= w_grant_id;
            r_ptr   <= ~w_grant_id;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_out   <= w_sum;
          r_rsp_cout  <= w_cout;
          r_rsp_ovf   <= w_ovf;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_out   = r_rsp_out;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_ovf   = r_rsp_ovf;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (WIDTH = 4).
module tb_addsub_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_sub = 1'b0, req1_sub = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic [3:0] rsp_out;
  logic       rsp_cout;
  logic       rsp_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  addsub_arbiter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_sub  (req0_sub),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_sub  (req1_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " rsp_valid"}, {7'd0, rsp_valid}, 8'd0);
    check({tag, " rsp_out"},   {4'd0, rsp_out},   8'd0);
    check({tag, " rsp_cout"},  {7'd0, rsp_cout},  8'd0);
    check({tag, " rsp_ovf"},   {7'd0, rsp_ovf},   8'd0);
    check({tag, " rsp_id"},    {7'd0, rsp_id},    8'd0);
    check({tag, " req_ready"}, {6'd0, req_ready}, 8'd0);
  endtask

  // One single-requester transaction with rsp_ready high; starts and ends on a negedge in IDLE.
  task automatic run_op(input string tag, input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic sub, input logic [3:0] e_out, input logic e_cout, input logic e_ovf);
    if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req_valid = 2'b10; end
    else    begin req0_a = a; req0_b = b; req0_sub = sub; req_valid = 2'b01; end
    #1 check({tag, " accept ready"}, {6'd0, req_ready}, id ? 8'h02 : 8'h01);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check({tag, " exec valid"}, {7'd0, rsp_valid}, 8'd0);
    @(negedge clk);
    check({tag, " rsp_valid"}, {7'd0, rsp_valid}, 8'd1);
    check({tag, " rsp_out"},   {4'd0, rsp_out},   {4'd0, e_out});
    check({tag, " rsp_cout"},  {7'd0, rsp_cout},  {7'd0, e_cout});
    check({tag, " rsp_ovf"},   {7'd0, rsp_ovf},   {7'd0, e_ovf});
    check({tag, " rsp_id"},    {7'd0, rsp_id},    {7'd0, id});
    check({tag, " resp ready"}, {6'd0, req_ready}, 8'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op("add0",  1'b0, 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0);
    run_op("add1",  1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    run_op("sub_a", 1'b0, 4'b0101, 4'b0010, 1'b1, 4'b0011, 1'b1, 1'b0);
    run_op("sub_b", 1'b0, 4'b0001, 4'b0010, 1'b1, 4'b1111, 1'b0, 1'b0);
    run_op("ovf_a", 1'b0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    run_op("ovf_s", 1'b1, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);

    // Both requesters valid continuously from a fresh reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_a = 4'd1; req0_b = 4'd1; req0_sub = 1'b0;
    req1_a = 4'd2; req1_b = 4'd1; req1_sub = 1'b1;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1 check($sformatf("rr grant %0d", g), {6'd0, req_ready}, (g % 2 == 1) ? 8'h02 : 8'h01);
      @(negedge clk);
      check($sformatf("rr exec ready %0d", g), {6'd0, req_ready}, 8'd0);
      @(negedge clk);
      check($sformatf("rr rsp_id %0d", g), {7'd0, rsp_id}, (g % 2 == 1) ? 8'd1 : 8'd0);
      check($sformatf("rr rsp_out %0d", g), {4'd0, rsp_out}, (g % 2 == 1) ? 8'd1 : 8'd2);
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Backpressure: response held for 5 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    req0_a = 4'd2; req0_b = 4'd3; req0_sub = 1'b0;
    req1_a = 4'b0110; req1_b = 4'b0011; req1_sub = 1'b0;
    req_valid = 2'b01;
    #1 check("bp accept", {6'd0, req_ready}, 8'h01);
    @(negedge clk);
    req_valid = 2'b10;
    #1 check("bp exec ready", {6'd0, req_ready}, 8'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp valid %0d", c), {7'd0, rsp_valid}, 8'd1);
      check($sformatf("bp out %0d", c),   {4'd0, rsp_out},   8'd5);
      check($sformatf("bp ready %0d", c), {6'd0, req_ready}, 8'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp released valid", {7'd0, rsp_valid}, 8'd0);
    check("bp idle grant",     {6'd0, req_ready}, 8'h02);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("bp req1 out",  {4'd0, rsp_out}, 8'h09);
    check("bp req1 ovf",  {7'd0, rsp_ovf}, 8'd1);
    check("bp req1 id",   {7'd0, rsp_id},  8'd1);
    @(negedge clk);

    // Reset during EXEC after a requester-0 grant (pointer at 1).
    run_op("pre_rst", 1'b0, 4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);
    req0_a = 4'd4; req0_b = 4'd4; req0_sub = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    #1 check_idle_outputs("rst exec");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post rst no rsp %0d", c), {7'd0, rsp_valid}, 8'd0);
    end
    req0_a = 4'd5; req0_b = 4'd1; req1_a = 4'd7; req1_b = 4'd7;
    req0_sub = 1'b0; req1_sub = 1'b0;
    req_valid = 2'b11;
    #1 check("post rst grant", {6'd0, req_ready}, 8'h01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("post rst rsp_id",  {7'd0, rsp_id},  8'd0);
    check("post rst rsp_out", {4'd0, rsp_out}, 8'd6);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
